cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter BLOCKSIZE, default 4, block of 2^BLOCKSIZE bytes.
REQ-002 SHALL have parameter ASSOC, default 2, number of ways (2 or 4).
REQ-003 SHALL have parameter SETS, default 2, set-index width in bits.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  1  CPU access request, sampled only when ready=1.
REQ-007 SHALL have port addr  input  32  CPU byte address, captured with req.
REQ-008 SHALL have port ready  output  1  controller idle and accepting req.
REQ-009 SHALL have port resp_valid  output  1  one-cycle pulse: access completed as hit.
REQ-010 SHALL have port lk_addr  output  32  latched address driven to cache array.
REQ-011 SHALL have port hit_in / hit_way  input  1 / ASSOC  registered hit flag and one-hot hit way from cache array.
REQ-012 SHALL have port mem_req / mem_addr / mem_ack  output 1 / output 32 / input 1  block refill handshake.
REQ-013 SHALL have port fill_en / fill_way / fill_set  output 1 / ASSOC / SETS  one-cycle write strobe, one-hot victim way, target set.

Function
REQ-014 FSM states SHALL be IDLE, LOOKUP, REFILL, FILL; ready=1 only in IDLE.
REQ-015 IDLE: req=1 -> latch addr into lk_addr, go LOOKUP; req=0 -> stay.
REQ-016 LOOKUP lasts exactly one cycle; hit_in sampled at its end (array hit latency 1 cycle).
REQ-017 LOOKUP with hit_in=1 -> resp_valid=1 next cycle, state IDLE; hit-to-ready latency 2 cycles from req.
REQ-018 LOOKUP with hit_in=0 -> REFILL; mem_addr = lk_addr with low BLOCKSIZE bits zeroed.
REQ-019 REFILL: mem_req and mem_addr SHALL stay constant until mem_ack=1 sampled; then FILL.
REQ-020 mem_ack outside REFILL SHALL be ignored.
REQ-021 FILL: fill_en=1 for exactly one cycle; fill_set = lk_addr[BLOCKSIZE+SETS-1:BLOCKSIZE]; fill_way = victim; next state LOOKUP (replay, which then hits).
REQ-022 Victim default: per-set round-robin pointer, advanced by one modulo ASSOC on each FILL of that set; wraps ASSOC-1 -> 0.
REQ-023 req/addr changes while ready=0 SHALL have no effect; lk_addr stable from capture until return to IDLE.
REQ-024 Outputs mem_req, fill_en, resp_valid SHALL be registered (no combinational path from inputs).

Reset
REQ-025 reset=1 at any clock edge, including mid-REFILL, SHALL force IDLE, ready=1, resp_valid=0, mem_req=0, fill_en=0, lk_addr=0, mem_addr=0, fill_way=0, fill_set=0.
REQ-026 reset SHALL clear all round-robin pointers and LRU state to way 0; an outstanding mem_ack after reset is ignored.

Configuration
REQ-027 Macro CACHE_LRU_EN defined: victim = least-recently-used way per set (true LRU for ASSOC=2, tree pseudo-LRU for 4), updated by hit_way on LOOKUP hit and by fill_way on FILL.
REQ-028 Macro CACHE_LRU_EN undefined: round-robin per REQ-022, hit_way ignored, no LRU storage synthesized.

Verification
REQ-029 Reset, req addr=0x40, hit_in=1 at LOOKUP -> resp_valid pulse at cycle 2, no mem_req.
REQ-030 req addr=0x1234, hit_in=0 -> mem_req=1, mem_addr=0x1230 held 5 cycles until mem_ack; fill_en one cycle, fill_set=3, fill_way=0b01; replay hit -> resp_valid.
REQ-031 Three misses to set 0 (no LRU macro) -> fill_way 0b01, 0b10, 0b01 (ASSOC=2 wrap).
REQ-032 With CACHE_LRU_EN: fill set 0 ways 0,1, hit way 0, miss set 0 -> fill_way=0b10.
REQ-033 reset asserted during REFILL -> next cycle mem_req=0, ready=1; late mem_ack produces no fill_en.
REQ-034 req toggled and addr changed during REFILL -> lk_addr and mem_addr unchanged, single completion.

Source files
------------

// File: rtl/cache_ctrl.sv
// Cache controller: request capture, one-cycle lookup, block refill and victim fill with replay.
// Victim selection is per-set round-robin unless CACHE_LRU_EN is defined (LRU / tree pseudo-LRU).
module cache_ctrl #(
    parameter int unsigned BLOCKSIZE = 4,
    parameter int unsigned ASSOC     = 2,
    parameter int unsigned SETS      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [31:0]       addr,
    output logic              ready,
    output logic              resp_valid,
    output logic [31:0]       lk_addr,
    input  logic              hit_in,
    input  logic [ASSOC-1:0]  hit_way,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    output logic              fill_en,
    output logic [ASSOC-1:0]  fill_way,
    output logic [SETS-1:0]   fill_set
);

    localparam int unsigned NumSets = 1 << SETS;
    localparam int unsigned WayW    = $clog2(ASSOC);

    typedef enum logic [1:0] {StIdle, StLookup, StRefill, StFill} state_e;

    state_e          state_q;
    logic [SETS-1:0] lk_set;
    logic [31:0]     blk_addr;
    logic [WayW-1:0] victim_idx;

    assign lk_set   = lk_addr[BLOCKSIZE+SETS-1:BLOCKSIZE];
    assign blk_addr = {lk_addr[31:BLOCKSIZE], {BLOCKSIZE{1'b0}}};

`ifdef CACHE_LRU_EN
    // Tree bits: [0] picks the LRU half, [1] LRU of ways 0/1, [2] LRU of ways 2/3.
    logic [2:0]      plru_q [NumSets];
    logic [2:0]      plru_cur;
    logic [WayW-1:0] hit_idx;

    function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [WayW-1:0] w);
        logic [2:0] r;
        r = t;
        if (ASSOC == 2) begin
            r[1] = ~w[0];
        end else if (w[WayW-1] == 1'b0) begin
            r[0] = 1'b1;
            r[1] = ~w[0];
        end else begin
            r[0] = 1'b0;
            r[2] = ~w[0];
        end
        return r;
    endfunction

    assign plru_cur = plru_q[lk_set];

    always_comb begin
        if (ASSOC == 2) begin
            victim_idx = WayW'(plru_cur[1]);
        end else if (plru_cur[0]) begin
            victim_idx = plru_cur[2] ? WayW'(3) : WayW'(2);
        end else begin
            victim_idx = plru_cur[1] ? WayW'(1) : WayW'(0);
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int unsigned i = 0; i < ASSOC; i++) begin
            if (hit_way[i]) begin
                hit_idx = WayW'(i);
            end
        end
    end
`else
    logic [WayW-1:0] rr_q [NumSets];
    logic            unused_hit_way;

    assign unused_hit_way = ^hit_way;
    assign victim_idx     = rr_q[lk_set];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            mem_req    <= 1'b0;
            fill_en    <= 1'b0;
            lk_addr    <= '0;
            mem_addr   <= '0;
            fill_way   <= '0;
            fill_set   <= '0;
            for (int unsigned i = 0; i < NumSets; i++) begin
`ifdef CACHE_LRU_EN
                plru_q[i] <= '0;
`else
                rr_q[i] <= '0;
`endif
            end
        end else begin
            resp_valid <= 1'b0;
            fill_en    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        lk_addr <= addr;
                        ready   <= 1'b0;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit_in) begin
                        resp_valid <= 1'b1;
                        ready      <= 1'b1;
                        state_q    <= StIdle;
`ifdef CACHE_LRU_EN
                        plru_q[lk_set] <= plru_touch(plru_cur, hit_idx);
`endif
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= blk_addr;
                        state_q  <= StRefill;
                    end
                end
                StRefill: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        fill_en  <= 1'b1;
                        fill_way <= ASSOC'(1) << victim_idx;
                        fill_set <= lk_set;
                        state_q  <= StFill;
`ifdef CACHE_LRU_EN
                        plru_q[lk_set] <= plru_touch(plru_cur, victim_idx);
`else
                        rr_q[lk_set] <= (victim_idx == WayW'(ASSOC - 1)) ? '0 : victim_idx + 1'b1;
`endif
                    end
                end
                StFill: begin
                    // Replay the lookup; the freshly filled block now hits.
                    state_q <= StLookup;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed vector table, corner-case sequences and a
// randomized run against a tag-store model; honours CACHE_LRU_EN for victim expectations.
module tb_cache_ctrl;

    localparam int unsigned BS = 4;
    localparam int unsigned AS = 2;
    localparam int unsigned SB = 2;
    localparam int unsigned NS = 4;

    logic          clk = 1'b0;
    logic          reset, req, hit_in, mem_ack;
    logic [31:0]   addr;
    logic [AS-1:0] hit_way;
    logic          ready, resp_valid, mem_req, fill_en;
    logic [31:0]   lk_addr, mem_addr;
    logic [AS-1:0] fill_way;
    logic [SB-1:0] fill_set;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cache_ctrl #(.BLOCKSIZE(BS), .ASSOC(AS), .SETS(SB)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .ready(ready),
        .resp_valid(resp_valid), .lk_addr(lk_addr), .hit_in(hit_in), .hit_way(hit_way),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .fill_en(fill_en),
        .fill_way(fill_way), .fill_set(fill_set)
    );

    typedef struct {
        logic [31:0]   a;
        bit            hit;
        int            delay;
        logic [AS-1:0] hway;
        bit            noise;
        logic [31:0]   mem_a;
        logic [SB-1:0] set;
        logic [AS-1:0] way;
    } vec_t;

    vec_t vecs[8];

    // Behavioural model: which block sits in each (set, way), plus victim bookkeeping.
    bit          valid_m [NS][AS];
    logic [27:0] blk_m   [NS][AS];
`ifdef CACHE_LRU_EN
    int          last_use_m [NS][AS];
    int          use_clock;
`else
    int          rr_m [NS];
`endif

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < AS; w++) begin
                valid_m[s][w] = 1'b0;
`ifdef CACHE_LRU_EN
                last_use_m[s][w] = 0;
`endif
            end
`ifndef CACHE_LRU_EN
            rr_m[s] = 0;
`endif
        end
`ifdef CACHE_LRU_EN
        use_clock = 0;
`endif
    endtask

    function automatic int victim_m(input int s);
`ifdef CACHE_LRU_EN
        int v = 0;
        for (int w = 1; w < AS; w++) begin
            if (last_use_m[s][w] < last_use_m[s][v]) v = w;
        end
        return v;
`else
        return rr_m[s];
`endif
    endfunction

    task automatic note_use(input int s, input int w, input bit is_fill);
`ifdef CACHE_LRU_EN
        use_clock++;
        last_use_m[s][w] = use_clock;
`else
        if (is_fill) rr_m[s] = (rr_m[s] + 1) % AS;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic rb(input bit noise);
        return noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; addr = '0; hit_in = 1'b0; hit_way = '0; mem_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_resp"}, 32'(resp_valid), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_fill_en"}, 32'(fill_en), 32'd0);
        chk({tag, "_lk_addr"}, lk_addr, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_fill_way"}, 32'(fill_way), 32'd0);
        chk({tag, "_fill_set"}, 32'(fill_set), 32'd0);
    endtask

    // One complete access from an idle controller, checked cycle by cycle.
    task automatic access(input logic [31:0] a, input bit hit, input int delay,
                          input logic [AS-1:0] hway, input bit noise, input logic [31:0] exp_mem,
                          input logic [SB-1:0] exp_set, input logic [AS-1:0] exp_way);
        chk("idle_ready", 32'(ready), 32'd1);
        req = 1'b1; addr = a; hit_in = rb(noise); mem_ack = rb(noise);
        step();
        chk("lookup_lk_addr", lk_addr, a);
        chk("lookup_ready", 32'(ready), 32'd0);
        chk("lookup_mem_req", 32'(mem_req), 32'd0);
        req = rb(noise); addr = noise ? $urandom : a;
        hit_in = hit; hit_way = hit ? hway : (noise ? AS'($urandom) : '0); mem_ack = rb(noise);
        step();
        if (hit) begin
            chk("hit_resp", 32'(resp_valid), 32'd1);
            chk("hit_ready", 32'(ready), 32'd1);
            chk("hit_no_mem_req", 32'(mem_req), 32'd0);
        end else begin
            for (int k = 1; k <= delay; k++) begin
                chk("refill_mem_req", 32'(mem_req), 32'd1);
                chk("refill_mem_addr", mem_addr, exp_mem);
                chk("refill_lk_addr", lk_addr, a);
                chk("refill_no_resp", 32'(resp_valid | fill_en | ready), 32'd0);
                req = rb(noise); addr = noise ? $urandom : a; hit_in = rb(noise);
                mem_ack = (k == delay);
                step();
            end
            chk("fill_en", 32'(fill_en), 32'd1);
            chk("fill_way", 32'(fill_way), 32'(exp_way));
            chk("fill_set", 32'(fill_set), 32'(exp_set));
            chk("fill_mem_req", 32'(mem_req), 32'd0);
            mem_ack = rb(noise); hit_in = rb(noise);
            step();
            chk("replay_fill_en", 32'(fill_en), 32'd0);
            chk("replay_ready", 32'(ready | resp_valid), 32'd0);
            chk("replay_lk_addr", lk_addr, a);
            hit_in = 1'b1; hit_way = exp_way; mem_ack = rb(noise);
            step();
            chk("replay_resp", 32'(resp_valid), 32'd1);
            chk("replay_ready_back", 32'(ready), 32'd1);
        end
        req = 1'b0; addr = '0; hit_in = 1'b0; hit_way = '0; mem_ack = 1'b0;
        step();
        chk("resp_single_pulse", 32'(resp_valid), 32'd0);
        chk("idle_again", 32'(ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [25:0] pool [6];
        logic [31:0] a;
        int          s, w, v;

        vecs[0] = '{32'h0000_0040, 1'b1, 0, 2'b10, 1'b0, 32'h0, 2'd0, 2'b00};
        vecs[1] = '{32'h0000_1234, 1'b0, 5, 2'b00, 1'b1, 32'h0000_1230, 2'd3, 2'b01};
        vecs[2] = '{32'h0000_0000, 1'b0, 1, 2'b00, 1'b0, 32'h0000_0000, 2'd0, 2'b01};
        vecs[3] = '{32'h0000_0108, 1'b0, 2, 2'b00, 1'b0, 32'h0000_0100, 2'd0, 2'b10};
        vecs[4] = '{32'h0000_020F, 1'b0, 3, 2'b00, 1'b0, 32'h0000_0200, 2'd0, 2'b01};
        vecs[5] = '{32'h0000_1238, 1'b0, 1, 2'b00, 1'b0, 32'h0000_1230, 2'd3, 2'b10};
        vecs[6] = '{32'hFFFF_FFFF, 1'b1, 0, 2'b01, 1'b0, 32'h0, 2'd0, 2'b00};
        vecs[7] = '{32'hABCD_EF5F, 1'b0, 2, 2'b00, 1'b1, 32'hABCD_EF50, 2'd1, 2'b01};

        do_reset();
        check_idle_reset("reset");
        for (int i = 0; i < 8; i++) begin
            access(vecs[i].a, vecs[i].hit, vecs[i].delay, vecs[i].hway, vecs[i].noise,
                   vecs[i].mem_a, vecs[i].set, vecs[i].way);
        end

        // Fill both ways of set 0, hit way 0, then miss: LRU evicts way 1, round-robin way 0.
        do_reset();
        access(32'h0000_0000, 1'b0, 1, 2'b00, 1'b0, 32'h0000_0000, 2'd0, 2'b01);
        access(32'h0000_0100, 1'b0, 1, 2'b00, 1'b0, 32'h0000_0100, 2'd0, 2'b10);
        access(32'h0000_0004, 1'b1, 0, 2'b01, 1'b0, 32'h0, 2'd0, 2'b00);
`ifdef CACHE_LRU_EN
        access(32'h0000_0200, 1'b0, 1, 2'b00, 1'b0, 32'h0000_0200, 2'd0, 2'b10);
`else
        access(32'h0000_0200, 1'b0, 1, 2'b00, 1'b0, 32'h0000_0200, 2'd0, 2'b01);
`endif

        // Reset in the middle of a refill, then a late mem_ack.
        do_reset();
        access(32'h0000_0000, 1'b0, 1, 2'b00, 1'b0, 32'h0000_0000, 2'd0, 2'b01);
        req = 1'b1; addr = 32'h0000_0300;
        step();
        req = 1'b0; hit_in = 1'b0;
        step();
        chk("rstmid_mem_req", 32'(mem_req), 32'd1);
        chk("rstmid_mem_addr", mem_addr, 32'h0000_0300);
        step();
        reset = 1'b1;
        step();
        check_idle_reset("rstmid");
        reset = 1'b0; mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("late_ack_fill_en", 32'(fill_en), 32'd0);
            chk("late_ack_mem_req", 32'(mem_req), 32'd0);
            chk("late_ack_ready", 32'(ready), 32'd1);
        end
        mem_ack = 1'b0;
        access(32'h0000_0100, 1'b0, 2, 2'b00, 1'b0, 32'h0000_0100, 2'd0, 2'b01);

        // Randomized run against the tag-store model.
        do_reset();
        model_reset();
        for (int p = 0; p < 6; p++) pool[p] = 26'($urandom);
        for (int n = 0; n < 300; n++) begin
            s = $urandom_range(0, NS - 1);
            a = {pool[$urandom_range(0, 5)], 2'(s), 4'($urandom_range(0, 15))};
            w = -1;
            for (int j = 0; j < AS; j++) begin
                if (valid_m[s][j] && blk_m[s][j] == a[31:4]) w = j;
            end
            if (w >= 0) begin
                access(a, 1'b1, 0, AS'(1) << w, 1'b1, 32'h0, 2'd0, '0);
                note_use(s, w, 1'b0);
            end else begin
                v = victim_m(s);
                access(a, 1'b0, $urandom_range(1, 4), '0, 1'b1, {a[31:4], 4'h0}, 2'(s),
                       AS'(1) << v);
                valid_m[s][v] = 1'b1;
                blk_m[s][v]   = a[31:4];
                note_use(s, v, 1'b1);
                note_use(s, v, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
